// File: rtl/syn_weight_engine.sv
// syn_weight_engine: packed synapse weight table with stochastic-fraction reads and saturating STDP updates
module syn_weight_engine #(
    parameter int N_SYN = 128,
    parameter int COLS = 4,
    parameter int INT_W = 8,
    parameter int FRAC_W = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int ADDR_W = $clog2(N_SYN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kill,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [COLS*INT_W-1:0]   load_data,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [ADDR_W-1:0]       upd_addr,
    input  logic [INT_W:0]          upd_delta,
    output logic                    out_valid,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [INT_W+FRAC_W-1:0] weight_out,
    output logic                    load_done,
    output logic [2:0]              state_o
);
    localparam int DEPTH = N_SYN / COLS;
    localparam int WA_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int COL_W = COLS > 1 ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    typedef enum logic [2:0] {CLEAR = 3'd0, LOAD = 3'd1, RUN = 3'd2, UPD_RD = 3'd3, UPD_WR = 3'd4} state_t;

    logic [COLS*INT_W-1:0] mem [DEPTH];
    logic [COLS*INT_W-1:0] mem_rd_q, mem_wd, wdata_d, wdata_q;
    logic                  mem_we;
    logic [WA_W-1:0]       mem_wa, mem_ra, wptr_d, wptr_q, upd_wa_d, upd_wa_q;
    state_t                state_d, state_q;
    logic [15:0]           lfsr_d, lfsr_q;
    logic                  load_done_d, load_done_q, s1_valid_d, s1_valid_q, out_valid_d, out_valid_q;
    logic [ADDR_W-1:0]     s1_addr_d, s1_addr_q, out_addr_d, out_addr_q;
    logic [INT_W+FRAC_W-1:0] weight_d, weight_q;
    logic [COL_W-1:0]      upd_col_d, upd_col_q, s1_col;
    logic [INT_W:0]        upd_delta_d, upd_delta_q;
    logic [INT_W-1:0]      cur_w, sat_w;
    logic signed [INT_W+1:0] sum;
    logic                  rd_acc, upd_acc, wrap;

    assign load_ready = state_q == LOAD && !kill;
    assign upd_ready  = state_q == RUN && !kill;
    assign rd_ready   = state_q == RUN && !kill && !upd_valid;
    assign upd_acc    = upd_valid && upd_ready;
    assign rd_acc     = rd_valid && rd_ready;
    assign wrap       = wptr_q == WA_W'(DEPTH - 1);
    assign s1_col     = COL_W'(s1_addr_q % COLS_A);
    assign mem_ra     = WA_W'((upd_acc ? upd_addr : rd_addr) / COLS_A);
    assign cur_w      = mem_rd_q[upd_col_q*INT_W +: INT_W];
    assign sum        = $signed({2'b00, cur_w}) + $signed({upd_delta_q[INT_W], upd_delta_q});
    assign sat_w      = sum[INT_W+1] ? '0 : sum[INT_W] ? '1 : sum[INT_W-1:0];
    assign lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        wdata_d = mem_rd_q;
        wdata_d[upd_col_q*INT_W +: INT_W] = sat_w;
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        load_done_d = load_done_q;
        mem_we      = 1'b0;
        mem_wa      = wptr_q;
        mem_wd      = '0;
        upd_wa_d    = upd_acc ? mem_ra : upd_wa_q;
        upd_col_d   = upd_acc ? COL_W'(upd_addr % COLS_A) : upd_col_q;
        upd_delta_d = upd_acc ? upd_delta : upd_delta_q;
        case (state_q)
            CLEAR: begin
                mem_we  = 1'b1;
                wptr_d  = wrap ? '0 : wptr_q + 1'b1;
                state_d = wrap ? LOAD : CLEAR;
            end
            LOAD: if (load_valid) begin
                mem_we      = 1'b1;
                mem_wd      = load_data;
                wptr_d      = wrap ? '0 : wptr_q + 1'b1;
                state_d     = wrap ? RUN : LOAD;
                load_done_d = wrap;
            end
            RUN: state_d = upd_acc ? UPD_RD : RUN;
            UPD_RD: state_d = UPD_WR;
            UPD_WR: begin
                mem_we  = 1'b1;
                mem_wa  = upd_wa_q;
                mem_wd  = wdata_q;
                state_d = RUN;
            end
            default: state_d = CLEAR;
        endcase
        if (kill) begin
            state_d     = CLEAR;
            wptr_d      = '0;
            load_done_d = 1'b0;
            mem_we      = 1'b0;
        end
    end

    assign s1_valid_d  = rd_acc;
    assign s1_addr_d   = rd_acc ? rd_addr : s1_addr_q;
    assign out_valid_d = s1_valid_q && !kill;
    assign out_addr_d  = s1_valid_q ? s1_addr_q : out_addr_q;
    assign weight_d    = s1_valid_q ? {mem_rd_q[s1_col*INT_W +: INT_W], lfsr_q[FRAC_W-1:0]} : weight_q;

    // Single write port, registered read port: maps onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        mem_rd_q <= mem[mem_ra];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            wptr_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            load_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            weight_q    <= '0;
            upd_wa_q    <= '0;
            upd_col_q   <= '0;
            upd_delta_q <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            lfsr_q      <= lfsr_d;
            load_done_q <= load_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            weight_q    <= weight_d;
            upd_wa_q    <= upd_wa_d;
            upd_col_q   <= upd_col_d;
            upd_delta_q <= upd_delta_d;
            wdata_q     <= wdata_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign weight_out = weight_q;
    assign load_done  = load_done_q;
    assign state_o    = state_q;
endmodule

// File: tb/tb_syn_weight_engine.sv
// tb_syn_weight_engine: directed and random stimulus against a weight-table reference model
module tb_syn_weight_engine;
    localparam int N_SYN = 128;
    localparam int COLS = 4;
    localparam int INT_W = 8;
    localparam int FRAC_W = 8;
    localparam int DEPTH = N_SYN / COLS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        rd_valid = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic        upd_valid = 1'b0;
    logic [6:0]  upd_addr = '0;
    logic [8:0]  upd_delta = '0;
    logic        load_ready, rd_ready, upd_ready, out_valid, load_done;
    logic [6:0]  out_addr;
    logic [15:0] weight_out;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    syn_weight_engine #(.N_SYN(N_SYN), .COLS(COLS), .INT_W(INT_W), .FRAC_W(FRAC_W), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .kill(kill),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_delta(upd_delta),
        .out_valid(out_valid), .out_addr(out_addr), .weight_out(weight_out),
        .load_done(load_done), .state_o(state_o)
    );

    typedef struct {
        int          due;
        int          addr;
        logic [15:0] w;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wt [N_SYN];
    logic [15:0] lfsr_m;
    int          phase, cnt, pend, p_addr, p_delta;
    bit          last_ra, last_ua;
    exp_t        q [$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int mstate();
        return phase == 0 ? 0 : phase == 1 ? 1 : pend == 2 ? 3 : pend == 1 ? 4 : 2;
    endfunction

    task automatic step();
        logic k, la, ua, ra, ev;
        int   ms, nv;
        exp_t e;
        #4;
        ms = mstate();
        k  = kill;
        la = load_valid && ms == 1 && !k;
        ua = upd_valid && ms == 2 && !k;
        ra = rd_valid && ms == 2 && !k && !upd_valid;
        if (!rst) begin
            check("load_ready", 32'(load_ready), 32'(ms == 1 && !k));
            check("upd_ready", 32'(upd_ready), 32'(ms == 2 && !k));
            check("rd_ready", 32'(rd_ready), 32'(ms == 2 && !k && !upd_valid));
        end
        @(posedge clk);
        #1;
        cyc++;
        last_ra = 0;
        last_ua = 0;
        if (rst || k) begin
            if (rst) lfsr_m = 16'hACE1;
            else lfsr_m = lfsr_m[0] ? (lfsr_m >> 1) ^ 16'hB400 : lfsr_m >> 1;
            q.delete();
            pend  = 0;
            phase = 0;
            cnt   = 0;
            foreach (wt[i]) wt[i] = 0;
        end else begin
            lfsr_m = lfsr_m[0] ? (lfsr_m >> 1) ^ 16'hB400 : lfsr_m >> 1;
            if (phase == 0) begin
                cnt++;
                if (cnt == DEPTH) begin
                    phase = 1;
                    cnt   = 0;
                end
            end else if (phase == 1) begin
                if (la) begin
                    for (int j = 0; j < COLS; j++) wt[cnt*COLS+j] = int'(load_data[j*8 +: 8]);
                    cnt++;
                    if (cnt == DEPTH) begin
                        phase = 2;
                        cnt   = 0;
                    end
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    nv = wt[p_addr] + p_delta;
                    wt[p_addr] = nv < 0 ? 0 : nv > 255 ? 255 : nv;
                end
            end else if (ua) begin
                pend    = 2;
                p_addr  = int'(upd_addr);
                p_delta = int'($signed(upd_delta));
                last_ua = 1;
            end else if (ra) begin
                e.due  = cyc + 1;
                e.addr = int'(rd_addr);
                e.w    = {8'(wt[rd_addr]), lfsr_m[7:0]};
                q.push_back(e);
                last_ra = 1;
            end
        end
        check("state_o", 32'(state_o), 32'(mstate()));
        check("load_done", 32'(load_done), 32'(phase == 2));
        ev = q.size() > 0 && q[0].due == cyc;
        check("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            e = q.pop_front();
            check("out_addr", 32'(out_addr), 32'(e.addr));
            check("weight_out", 32'(weight_out), 32'(e.w));
        end
    endtask

    task automatic load_table(int mode);
        for (int i = 0; i < 100 && phase == 0; i++) step();
        for (int i = 0; i < 300 && phase == 1; i++) begin
            load_valid = ($urandom % 4) != 0;
            load_data  = mode == 0 ? {4{8'(cnt)}} : mode == 1 ? 32'h0 : $urandom;
            step();
        end
        load_valid = 1'b0;
        check("load_complete", 32'(phase), 32'd2);
    endtask

    task automatic do_read(int a);
        rd_valid = 1'b1;
        rd_addr  = 7'(a);
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_ra) break;
        end
        check("rd_accept", 32'(last_ra), 32'd1);
        rd_valid = 1'b0;
    endtask

    task automatic do_upd(int a, int d);
        upd_valid = 1'b1;
        upd_addr  = 7'(a);
        upd_delta = 9'(d);
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_ua) break;
        end
        check("upd_accept", 32'(last_ua), 32'd1);
        upd_valid = 1'b0;
        for (int i = 0; i < 10 && pend > 0; i++) step();
    endtask

    initial begin
        int a;
        rst = 1'b1;
        step();
        rst = 1'b0;
        load_table(0);
        do_read(6);
        repeat (3) step();
        do_upd(9, 252);
        do_upd(9, 5);
        do_upd(10, 1);
        do_upd(10, -7);
        for (int i = 8; i < 12; i++) do_read(i);
        repeat (3) step();
        rd_valid  = 1'b1;
        rd_addr   = 7'd9;
        upd_valid = 1'b1;
        upd_addr  = 7'd9;
        upd_delta = 9'h1FF;
        step();
        check("upd_priority", 32'(last_ua), 32'd1);
        upd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_ra) break;
        end
        check("rd_after_upd", 32'(last_ra), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 7'(i * 5);
            step();
        end
        rd_valid = 1'b0;
        repeat (3) step();
        rd_valid = 1'b1;
        rd_addr  = 7'd20;
        step();
        rd_valid  = 1'b0;
        upd_valid = 1'b1;
        upd_addr  = 7'd20;
        upd_delta = 9'd50;
        step();
        upd_valid = 1'b0;
        kill = 1'b1;
        step();
        kill = 1'b0;
        load_table(1);
        a = 0;
        rd_valid = 1'b1;
        for (int i = 0; i < 300 && a < N_SYN; i++) begin
            rd_addr = 7'(a);
            step();
            if (last_ra) a++;
        end
        rd_valid = 1'b0;
        check("all_read", 32'(a), 32'(N_SYN));
        repeat (3) step();
        rd_valid = 1'b1;
        rd_addr  = 7'd30;
        step();
        rd_valid = 1'b0;
        kill = 1'b1;
        step();
        kill = 1'b0;
        load_table(2);
        for (int i = 0; i < 3000; i++) begin
            rd_valid   = $urandom % 2 == 0;
            rd_addr    = 7'($urandom);
            upd_valid  = $urandom % 4 == 0;
            upd_addr   = 7'($urandom);
            upd_delta  = 9'($urandom);
            load_valid = $urandom % 2 == 0;
            load_data  = $urandom;
            kill       = $urandom % 1000 == 0;
            step();
        end
        rd_valid   = 1'b0;
        upd_valid  = 1'b0;
        load_valid = 1'b0;
        kill       = 1'b0;
        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
